// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the unified memory.
interface mem_arbiter_if;

  logic        req0, req1;
  logic        we0, we1;
  logic [31:0] adr0, adr1;
  logic [31:0] wd0, wd1;
  logic        ack0, ack1;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_adr, mem_wd;
  logic [31:0] mem_rd;
  logic        busy, gnt;

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wd0, wd1, mem_rd,
    output ack0, ack1, rdata, mem_en, mem_we, mem_adr, mem_wd, busy, gnt
  );

  modport master (
    output req0, req1, we0, we1, adr0, adr1, wd0, wd1, mem_rd,
    input  ack0, ack1, rdata, mem_en, mem_we, mem_adr, mem_wd, busy, gnt
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the port not granted last wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_gnt
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_gnt = ~i_last;
    end else if (i_req1) begin
      o_gnt = PORT_DBG;
    end else begin
      o_gnt = PORT_CORE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single memory with a fixed WAIT-cycle access window.
//   state  | meaning
//   IDLE   | no transaction, requests sampled for arbitration
//   ACCESS | memory enabled for WAIT cycles on the latched request
//   DONE   | one-cycle ack to the granted port
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT = 2
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last;
  logic             r_gnt;
  logic             r_mem_en;
  logic             r_mem_we;
  logic [31:0]      r_mem_adr;
  logic [31:0]      r_mem_wd;
  logic             r_ack0;
  logic             r_ack1;
  logic [31:0]      r_rdata;

  logic w_valid;
  logic w_pick;

  rr_arbiter2 u_rr (
    .i_req0  (bus.req0),
    .i_req1  (bus.req1),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_gnt   (w_pick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_last    <= PORT_DBG;
      r_gnt     <= PORT_CORE;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_adr <= '0;
      r_mem_wd  <= '0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state   <= ACCESS;
            r_cnt     <= '0;
            r_gnt     <= w_pick;
            r_last    <= w_pick;
            r_mem_en  <= 1'b1;
            r_mem_we  <= (w_pick == PORT_DBG) ? bus.we1  : bus.we0;
            r_mem_adr <= (w_pick == PORT_DBG) ? bus.adr1 : bus.adr0;
            r_mem_wd  <= (w_pick == PORT_DBG) ? bus.wd1  : bus.wd0;
          end
        end
        ACCESS: begin
          if (r_cnt == CNT_LAST) begin
            r_state  <= DONE;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            // r_mem_we still holds the latched direction on this edge
            if (!r_mem_we) begin
              r_rdata <= bus.mem_rd;
            end
            r_ack0 <= (r_gnt == PORT_CORE);
            r_ack1 <= (r_gnt == PORT_DBG);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0    = r_ack0;
  assign bus.ack1    = r_ack1;
  assign bus.rdata   = r_rdata;
  assign bus.mem_en  = r_mem_en;
  assign bus.mem_we  = r_mem_we;
  assign bus.mem_adr = r_mem_adr;
  assign bus.mem_wd  = r_mem_wd;
  assign bus.busy    = (r_state != IDLE);
  assign bus.gnt     = r_gnt;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT, default 2, meaning memory access cycles per transaction (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, with synchronous, active-high reset.
REQ-004 The block SHALL have ports req0/req1, input, 1 each, meaning transaction request from port 0 (core) and port 1 (debug/DMA loader).
REQ-005 The block SHALL have ports we0/we1, input, 1 each, meaning 1 for write, 0 for read.
REQ-006 The block SHALL have ports adr0/adr1, input, 32 each, meaning byte address.
REQ-007 The block SHALL have ports wd0/wd1, input, 32 each, meaning write data.
REQ-008 The block SHALL have ports ack0/ack1, output, 1 each, meaning one-cycle transaction-complete pulse.
REQ-009 The block SHALL have port rdata, output, 32, meaning registered read data of the last completed read.
REQ-010 The block SHALL have ports mem_en, mem_we, output, 1 each, meaning unified memory enable and write strobe.
REQ-011 The block SHALL have ports mem_adr and mem_wd, output, 32 each, meaning memory address and write data.
REQ-012 The block SHALL have port mem_rd, input, 32, meaning memory read data, valid in the last ACCESS cycle.
REQ-013 The block SHALL have ports busy, output, 1, meaning a transaction is in flight, and gnt, output, 1, meaning the currently or last granted port id.

Function
REQ-014 The FSM SHALL have states IDLE, ACCESS, DONE; IDLE->ACCESS on any req, ACCESS->DONE when wait counter reaches WAIT-1, DONE->IDLE unconditionally.
REQ-015 In IDLE with exactly one req high, that port SHALL be granted at the next edge.
REQ-016 In IDLE with both req high, the port not granted last SHALL win (round robin); the last-grant register SHALL reset to 1 so port 0 wins the first tie.
REQ-017 On grant, the granted port's adr/wd/we SHALL be registered into mem_adr/mem_wd/mem_we; inputs are not sampled again until the next IDLE.
REQ-018 mem_en SHALL be high for exactly WAIT cycles (all ACCESS cycles); mem_we SHALL equal the latched we during ACCESS and 0 otherwise.
REQ-019 For reads, mem_rd SHALL be captured into rdata at the edge leaving ACCESS; rdata SHALL be unchanged by writes and SHALL hold until the next read completes.
REQ-020 The granted port's ack SHALL be high only in DONE (1 cycle), and the other ack SHALL stay 0.
REQ-021 Latency: with req sampled in IDLE at cycle 0, ACCESS SHALL span cycles 1..WAIT, ack SHALL occur in cycle WAIT+1, and the earliest next ACCESS SHALL be cycle WAIT+3.
REQ-022 The wait counter SHALL be 4 bits, clear on entering ACCESS, and not wrap within a transaction.
REQ-023 Requesters SHALL hold req/adr/we/wd until ack; req dropping mid-transaction SHALL NOT abort it (ack still pulses).
REQ-024 busy SHALL be high in ACCESS and DONE, and gnt SHALL update only on grant.

Reset
REQ-025 Reset SHALL force IDLE at the edge, and the next cycle SHALL have mem_en=0, mem_we=0, mem_adr=0, mem_wd=0, ack0=ack1=0, rdata=0, busy=0, gnt=0, counter=0, last-grant=1.
REQ-026 Reset mid-ACCESS/DONE SHALL abandon the transaction with no ack and no rdata update.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state enum (IDLE, ACCESS, DONE) and port-id constants PORT_CORE=0, PORT_DBG=1.
REQ-028 One sub-module, rr_arbiter2, SHALL be used: combinational 2-way round-robin pick from req0, req1 and last.

Verification
REQ-029 The bench SHALL cover a single read: WAIT=2, req0 read adr=0x100, mem_rd=0xDEADBEEF -> mem_en high cycles 1-2, ack0 in cycle 3, rdata=0xDEADBEEF.
REQ-030 The bench SHALL cover a single write: req1 we=1 adr=0x40 wd=0x12345678 -> mem_we=1 for 2 cycles with mem_adr=0x40, ack1 in cycle 3, rdata unchanged.
REQ-031 The bench SHALL cover a tie after reset: req0=req1=1 held -> grants alternate 0,1,0,1 and acks spaced WAIT+2 cycles apart.
REQ-032 The bench SHALL cover reset mid-ACCESS: reset asserted in cycle 1 of a read -> no ack, rdata=0, mem_en=0 the next cycle, port 0 wins the next tie.
REQ-033 The bench SHALL cover a WAIT=1 back-to-back read on port 0 -> ack cycles 2 and 5, mem_en never high in DONE/IDLE.
REQ-034 The bench SHALL cover a req drop: req0 deasserted in cycle 1 -> transaction completes, ack0 in cycle WAIT+1.
